// File: rtl/imem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | imem_pkg : shared types and constants for the instruction memory   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package imem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam int          IMEM_WORDS = 64;

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | imem_ram : 2**AW x 32 RAM, sync write, async read, per-word valid  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module imem_ram
    import imem_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    localparam int c_DEPTH = 2**AW;

    logic [31:0]        r_mem [c_DEPTH];
    logic [c_DEPTH-1:0] r_valid;

    // Storage itself is never reset; only the valid bits gate what the CPU sees.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_clr) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_waddr] <= 1'b1;
        end
    end

    assign o_rdata = r_valid[i_raddr] ? r_mem[i_raddr] : NOP_INSTR;

endmodule : imem_ram
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | imem_loader : byte-stream loader and CPU fetch port for the IMEM   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module imem_loader
    import imem_pkg::*;
#(
    parameter int AW         = 6,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load_start,
    input  logic [6:0]    load_len,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    input  logic [AW-1:0] addr,
    output logic [31:0]   instr,
    output logic          cpu_hold,
    output logic          load_done,
    output logic [6:0]    words_loaded
);

    localparam int         c_MAX     = (2**AW < IMEM_WORDS) ? 2**AW : IMEM_WORDS;
    localparam logic [6:0] c_MAX_LEN = 7'(c_MAX);

    state_t        r_state;
    logic [6:0]    r_len;
    logic [6:0]    r_words;
    logic [1:0]    r_bcnt;
    logic [23:0]   r_shift;
    logic [AW-1:0] r_waddr;
    logic          r_byte_ready;
    logic          r_cpu_hold;
    logic          r_load_done;

    logic          w_fire;
    logic          w_we;
    logic          w_start;
    logic          w_last;
    logic [6:0]    w_len;
    logic [31:0]   w_wdata;

    assign w_fire  = byte_valid && r_byte_ready;
    assign w_we    = w_fire && (r_bcnt == 2'd3);
    assign w_start = load_start && (r_state != ST_LOAD);
    assign w_len   = (load_len > c_MAX_LEN) ? c_MAX_LEN : load_len;
    assign w_last  = ((r_words + 7'd1) == r_len);

    // The word is formed from the three held bytes plus the byte on the bus now.
    generate
        if (BIG_ENDIAN) begin : g_be
            assign w_wdata = {r_shift, byte_data};
        end else begin : g_le
            assign w_wdata = {byte_data, r_shift[7:0], r_shift[15:8], r_shift[23:16]};
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_words      <= '0;
            r_bcnt       <= '0;
            r_shift      <= '0;
            r_waddr      <= '0;
            r_byte_ready <= 1'b0;
            r_cpu_hold   <= 1'b1;
            r_load_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (load_start) begin
                        r_len   <= w_len;
                        r_words <= '0;
                        r_waddr <= '0;
                        r_bcnt  <= '0;
                        if (w_len == 7'd0) begin
                            r_state      <= ST_DONE;
                            r_byte_ready <= 1'b0;
                            r_cpu_hold   <= 1'b0;
                            r_load_done  <= 1'b1;
                        end else begin
                            r_state      <= ST_LOAD;
                            r_byte_ready <= 1'b1;
                            r_cpu_hold   <= 1'b1;
                            r_load_done  <= 1'b0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_fire) begin
                        r_bcnt  <= r_bcnt + 2'd1;
                        r_shift <= {r_shift[15:0], byte_data};
                        if (w_we) begin
                            r_waddr <= r_waddr + 1'b1;
                            r_words <= r_words + 7'd1;
                            // Drop ready on the same edge so no byte past the last word is taken.
                            if (w_last) begin
                                r_state      <= ST_DONE;
                                r_byte_ready <= 1'b0;
                                r_cpu_hold   <= 1'b0;
                                r_load_done  <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_byte_ready <= 1'b0;
                    r_cpu_hold   <= 1'b1;
                    r_load_done  <= 1'b0;
                end
            endcase
        end
    end

    imem_ram #(
        .AW (AW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_clr   (w_start),
        .i_we    (w_we),
        .i_waddr (r_waddr),
        .i_wdata (w_wdata),
        .i_raddr (addr),
        .o_rdata (instr)
    );

    assign byte_ready   = r_byte_ready;
    assign cpu_hold     = r_cpu_hold;
    assign load_done    = r_load_done;
    assign words_loaded = r_words;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_imem_loader : randomized bench with a byte-level reference model|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load_start = 1'b0;
    logic [6:0]  load_len = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic [5:0]  addr = '0;

    logic        be_ready, le_ready, be_hold, le_hold, be_done, le_done;
    logic [31:0] be_instr, le_instr;
    logic [6:0]  be_words, le_words;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    imem_loader #(.AW(6), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .reset_n(reset_n), .load_start(load_start), .load_len(load_len),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(be_ready),
        .addr(addr), .instr(be_instr), .cpu_hold(be_hold), .load_done(be_done),
        .words_loaded(be_words)
    );

    imem_loader #(.AW(6), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .reset_n(reset_n), .load_start(load_start), .load_len(load_len),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(le_ready),
        .addr(addr), .instr(le_instr), .cpu_hold(le_hold), .load_done(le_done),
        .words_loaded(le_words)
    );

    // Reference model: counts accepted bytes of the current load and
    // rebuilds words from them in both byte orders.
    bit          m_active = 1'b0;
    bit          m_done   = 1'b0;
    int          m_len    = 0;
    int          m_bytes  = 0;
    logic [7:0]  m_cur [4];
    logic [31:0] m_be  [64];
    logic [31:0] m_le  [64];
    bit          m_valid [64];
    int          hs_cnt = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_bytes  = 0;
            m_len    = 0;
            for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        end else begin
            if (byte_valid && be_ready) hs_cnt++;
            if (m_active) begin
                if (byte_valid) begin
                    m_cur[m_bytes % 4] = byte_data;
                    m_bytes++;
                    if (m_bytes % 4 == 0) begin
                        int w;
                        w = m_bytes / 4 - 1;
                        m_be[w] = {m_cur[0], m_cur[1], m_cur[2], m_cur[3]};
                        m_le[w] = {m_cur[3], m_cur[2], m_cur[1], m_cur[0]};
                        m_valid[w] = 1'b1;
                        if (m_bytes / 4 == m_len) begin
                            m_active = 1'b0;
                            m_done   = 1'b1;
                        end
                    end
                end
            end else if (load_start) begin
                m_len   = (int'(load_len) > 64) ? 64 : int'(load_len);
                m_bytes = 0;
                for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
                m_active = (m_len != 0);
                m_done   = (m_len == 0);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [31:0] e_be, e_le;
        e_be = m_valid[addr] ? m_be[addr] : 32'h0;
        e_le = m_valid[addr] ? m_le[addr] : 32'h0;
        chk("be.byte_ready", {31'b0, be_ready}, {31'b0, m_active});
        chk("le.byte_ready", {31'b0, le_ready}, {31'b0, m_active});
        chk("be.cpu_hold",   {31'b0, be_hold},  {31'b0, !m_done});
        chk("le.cpu_hold",   {31'b0, le_hold},  {31'b0, !m_done});
        chk("be.load_done",  {31'b0, be_done},  {31'b0, m_done});
        chk("le.load_done",  {31'b0, le_done},  {31'b0, m_done});
        chk("be.words_loaded", {25'b0, be_words}, 32'(m_bytes / 4));
        chk("le.words_loaded", {25'b0, le_words}, 32'(m_bytes / 4));
        chk("be.instr", be_instr, e_be);
        chk("le.instr", le_instr, e_le);
    endtask

    bit last_hs;

    // One cycle: compare on the falling edge, return just after the rising edge.
    task automatic tick();
        logic seen;
        @(negedge clk);
        compare_all();
        seen = be_ready;
        @(posedge clk);
        last_hs = byte_valid && seen;
        #1;
    endtask

    task automatic peek(input int a);
        addr = 6'(a);
        tick();
    endtask

    task automatic start_load(input int n);
        load_start = 1'b1;
        load_len   = 7'(n);
        tick();
        load_start = 1'b0;
    endtask

    logic [7:0] bq [$];

    // mode 0: valid held, 1: valid every other cycle, 2: random gaps and stray load_start
    task automatic send_bytes(input int mode);
        foreach (bq[i]) begin
            int tries;
            if (mode == 1) begin
                byte_valid = 1'b0;
                tick();
            end else if (mode == 2) begin
                repeat ($urandom_range(0, 2)) begin
                    byte_valid = 1'b0;
                    addr = 6'($urandom_range(0, 63));
                    tick();
                end
            end
            byte_valid = 1'b1;
            byte_data  = bq[i];
            addr       = 6'($urandom_range(0, 63));
            if (mode == 2 && $urandom_range(0, 7) == 0) begin
                load_start = 1'b1;
                load_len   = 7'($urandom_range(0, 127));
            end
            tries = 0;
            do begin
                tick();
                load_start = 1'b0;
                tries++;
            end while (!last_hs && tries < 20);
            if (!last_hs) begin
                n_checks++;
                n_err++;
                $display("FAIL byte_timeout: byte %0d not accepted within 20 cycles", i);
                break;
            end
        end
        byte_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        reset_n = 1'b0;
        tick();
        tick();
        chk("rst.cpu_hold", {31'b0, be_hold}, 32'h1);
        chk("rst.byte_ready", {31'b0, be_ready}, 32'h0);
        chk("rst.words_loaded", {25'b0, be_words}, 32'h0);
        reset_n = 1'b1;
        tick();

        // Two-word load, valid held high
        start_load(2);
        bq = '{8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h03, 8'h00, 8'h0c};
        send_bytes(0);
        chk("t1.load_done", {31'b0, be_done}, 32'h1);
        chk("t1.cpu_hold", {31'b0, be_hold}, 32'h0);
        chk("t1.words_loaded", {25'b0, be_words}, 32'd2);
        peek(0); chk("t1.addr0", be_instr, 32'h20020005);
        peek(1); chk("t1.addr1", be_instr, 32'h2003000c);
        peek(2); chk("t1.addr2", be_instr, 32'h00000000);
        peek(0); chk("t1.le_addr0", le_instr, 32'h05000220);

        // Same load with byte_valid toggling
        hs0 = hs_cnt;
        start_load(2);
        send_bytes(1);
        chk("t2.handshakes", 32'(hs_cnt - hs0), 32'd8);
        chk("t2.ready_after", {31'b0, be_ready}, 32'h0);
        peek(0); chk("t2.addr0", be_instr, 32'h20020005);
        peek(1); chk("t2.addr1", be_instr, 32'h2003000c);

        // Zero-length load
        hs0 = hs_cnt;
        start_load(0);
        chk("t3.load_done", {31'b0, be_done}, 32'h1);
        byte_valid = 1'b1;
        byte_data  = 8'hff;
        for (int a = 0; a < 64; a++) begin
            peek(a);
            chk("t3.instr", be_instr, 32'h0);
        end
        byte_valid = 1'b0;
        chk("t3.handshakes", 32'(hs_cnt - hs0), 32'd0);

        // Over-length request clamps to the full memory
        start_load(100);
        bq.delete();
        for (int i = 0; i < 256; i++) bq.push_back(8'($urandom));
        send_bytes(0);
        chk("t4.load_done", {31'b0, be_done}, 32'h1);
        chk("t4.words_loaded", {25'b0, be_words}, 32'd64);
        repeat (3) tick();
        chk("t4.ready_idle", {31'b0, be_ready}, 32'h0);

        // Reload from DONE; previously valid words must vanish
        start_load(1);
        bq = '{8'h05, 8'h00, 8'h02, 8'h20};
        send_bytes(0);
        peek(0); chk("t5.le_addr0", le_instr, 32'h20020005);
        chk("t5.be_addr0", be_instr, 32'h05000220);
        peek(1); chk("t5.le_addr1", le_instr, 32'h0);

        // Reset in the middle of a load
        start_load(2);
        bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_bytes(0);
        reset_n = 1'b0;
        addr = 6'd0;
        #1;
        chk("t6.hold_in_rst", {31'b0, be_hold}, 32'h1);
        chk("t6.addr0_in_rst", be_instr, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("t6.ready_idle", {31'b0, be_ready}, 32'h0);
        start_load(1);
        bq = '{8'hac, 8'h67, 8'h00, 8'h44};
        send_bytes(0);
        peek(0); chk("t6.addr0", be_instr, 32'hac670044);
        peek(1); chk("t6.addr1", be_instr, 32'h0);

        // Randomized loads with gaps and stray load_start pulses
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(1, 12);
            start_load(n);
            bq.delete();
            for (int i = 0; i < 4 * n; i++) bq.push_back(8'($urandom));
            send_bytes(2);
            for (int a = 0; a < 16; a++) peek($urandom_range(0, 63));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule : tb_imem_loader
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writable instruction memory with a byte-stream load port. It is the writer side of the CPU's instruction fetch interface.
- A boot source (UART bridge or testbench) streams program bytes in over a valid/ready handshake.
- The block assembles the bytes into 32-bit words and writes them into a 64-word RAM.
- The single-cycle CPU fetches from the same RAM through the existing combinational addr/instr port.
- The CPU is held off via cpu_hold until a load completes.

Parameters:
AW, 6, word-address width; depth = 2**AW words.
BIG_ENDIAN, 1, 1: first byte of each word is instr[31:24]; 0: first byte is instr[7:0].

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
load_start  input  1  single-cycle pulse; begins a load of load_len words
load_len  input  7  number of words to load; sampled when load_start is accepted
byte_valid  input  1  byte_data holds a valid program byte
byte_data  input  8  program byte
byte_ready  output  1  loader accepts a byte this cycle
addr  input  AW  CPU fetch word address
instr  output  32  fetched instruction, combinational
cpu_hold  output  1  CPU must stall or stay in reset while high
load_done  output  1  high when the last load completed
words_loaded  output  7  number of words written by the current or last load

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; byte counter, word address and words_loaded cleared to 0.
  - All 64 valid bits cleared.
  - byte_ready=0, load_done=0, cpu_hold=1.
  - RAM contents are not reset.
- States and transitions:
  - IDLE: byte_ready=0, cpu_hold=1. load_start -> LOAD.
  - LOAD: byte_ready=1, cpu_hold=1. After the final word is written -> DONE.
  - DONE: byte_ready=0, cpu_hold=0, load_done=1. load_start -> LOAD (reload).
- Load start, when load_start is accepted in IDLE or DONE:
  - Latch len = min(load_len, 64).
  - Clear all valid bits, words_loaded, word address and byte counter.
  - load_done=0 and cpu_hold=1 from the next cycle.
  - If len==0, go directly to DONE next cycle; no writes occur.
- Load start while in LOAD: load_start is ignored.
- Byte transfer:
  - A byte is transferred on any cycle with byte_valid && byte_ready.
  - byte_valid may drop between bytes; gaps of any length are legal.
  - Bytes go into a 24-bit shift register, indexed by a 2-bit byte counter.
- Word write:
  - On the 4th accepted byte, the assembled word (3 held bytes plus the current byte) is written to RAM[word_addr] in that same clock edge.
  - The valid bit for that address is set; word_addr and words_loaded increment.
  - The byte counter wraps to 0.
- End of load:
  - When words_loaded reaches len on that edge, the next state is DONE.
  - byte_ready is 0 in the following cycle, so no extra byte is accepted.
- Fetch port:
  - instr = valid[addr] ? RAM[addr] : 32'h00000000 (an unwritten word reads as a MIPS nop).
  - Purely combinational.
  - A word written on edge N is visible on instr from edge N onward.
- Reset mid-load (reset_n low in LOAD): abort immediately to IDLE. Partial bytes are discarded, all valid bits cleared, cpu_hold=1.
- words_loaded never exceeds 64. The word address never wraps, because len is clamped.

Decomposition:
- Shared package imem_pkg:
  - State enum (IDLE, LOAD, DONE).
  - NOP_INSTR = 32'h00000000.
  - IMEM_WORDS = 64.
- One sub-module: imem_ram.
  - 64x32 storage with a synchronous write port (we, waddr, wdata).
  - Asynchronous read port.
  - Holds the valid-bit array with a clear input.
- imem_loader contains the FSM, the byte assembler and the counters.

Test Plan:
- Reset, then load_start with load_len=2. Stream 20 02 00 05 20 03 00 0c with byte_valid held high. Required:
  - addr=0 reads 20020005 and addr=1 reads 2003000c.
  - addr=2 reads 00000000.
  - load_done and cpu_hold=0 one cycle after the 8th byte.
  - words_loaded=2.
- Same load with byte_valid toggling every other cycle -> identical RAM contents; exactly 8 handshakes counted; byte_ready is 0 after the final byte.
- load_start with load_len=0 -> DONE next cycle; no byte accepted; instr=0 at all addresses.
- load_len=100, stream 256 bytes -> 64 words written, load_done after byte 256, words_loaded=64.
- Mid-load reset_n pulse after 6 bytes of a 2-word load. Required:
  - IDLE, cpu_hold=1.
  - addr=0 reads 0.
  - A fresh load of one word (ac 67 00 44) then reads ac670044 at addr 0.
- Reload from DONE with load_len=1 and BIG_ENDIAN=0, bytes 05 00 02 20 -> addr0=20020005, addr1 now reads 0 (valid bits cleared).
